// File: rtl/dm_pkg.sv
// Shared definitions for the pipelined data memory: latency bounds, state
// encoding and byte-address helpers.
package dm_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 8;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dm_state_e;

    // Word index of a byte address, for a word of 2**lg_bytes bytes.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input int unsigned lg_bytes);
        return addr >> lg_bytes;
    endfunction

    function automatic logic is_aligned(input logic [31:0] addr,
                                        input int unsigned lg_bytes);
        return (addr & ((32'd1 << lg_bytes) - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/dm_sram.sv
// Word-wide synchronous storage array with byte-strobed write and a read
// register that only updates on a read strobe. No reset on purpose.
module dm_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTES      = DATA_WIDTH / 8,
    parameter int IDX_W      = 12,
    parameter int MEM_DEPTH  = 2 ** IDX_W
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [BYTES-1:0]      be_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be_i[i]) begin
                    mem[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Holding the last read keeps DM_out stable across writes and idle time.
    always_ff @(posedge clock) begin
        if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_pipelined.sv
// Data memory with configurable access latency, byte strobes, alignment and
// command checking; one access in flight at a time.
module dm_pipelined
    import dm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    DM_enable,
    input  logic                    DM_read,
    input  logic                    DM_write,
    input  logic [ADDR_WIDTH-1:0]   DM_address,
    input  logic [DATA_WIDTH-1:0]   DM_in,
    input  logic [DATA_WIDTH/8-1:0] DM_byte_en,
    output logic [DATA_WIDTH-1:0]   DM_out,
    output logic                    DM_ready,
    output logic                    DM_error
);

    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int unsigned LG_BYTES  = $clog2(BYTES);
    localparam int          IDX_W     = ADDR_WIDTH - int'(LG_BYTES);
    localparam int          MEM_DEPTH = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    dm_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BYTES-1:0]      be_q;
    logic                  wr_q;
    logic                  rej_q;
    logic                  err_q;
    logic                  out_vld_q;

    logic                  accept;
    logic                  complete;
    logic                  sram_we;
    logic                  sram_re;
    logic [IDX_W-1:0]      sram_idx;
    logic [DATA_WIDTH-1:0] sram_rdata;

    assign DM_ready = (state_q == ST_IDLE);
    assign accept   = DM_ready && DM_enable && (DM_read || DM_write);
    assign complete = (state_q == ST_BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = LAT_M1;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            rej_q     <= 1'b0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= complete && rej_q;
            if (sram_re) begin
                out_vld_q <= 1'b1;
            end
            if (accept) begin
                addr_q <= DM_address;
                data_q <= DM_in;
                be_q   <= DM_byte_en;
                wr_q   <= DM_write && !DM_read;
                rej_q  <= !is_aligned(32'(DM_address), LG_BYTES)
                          || (DM_read && DM_write);
            end
        end
    end

    // The array is strobed during the cycle ending at the completion edge,
    // so its registered read data appears exactly at completion.
    assign sram_we  = complete && !rej_q && wr_q;
    assign sram_re  = complete && !rej_q && !wr_q;
    assign sram_idx = IDX_W'(word_index(32'(addr_q), LG_BYTES));

    dm_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTES      (BYTES),
        .IDX_W      (IDX_W),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_sram (
        .clock   (clock),
        .we_i    (sram_we),
        .be_i    (be_q),
        .idx_i   (sram_idx),
        .wdata_i (data_q),
        .re_i    (sram_re),
        .rdata_o (sram_rdata)
    );

    // The array has no reset, so DM_out reads as zero until a read completes.
    assign DM_out   = out_vld_q ? sram_rdata : '0;
    assign DM_error = err_q;

endmodule

// File: tb/tb_dm_pipelined.sv
// Directed bench for dm_pipelined: one instance at LATENCY=2 for the function
// and boundary cases, three more at LATENCY=1/4/8 for the latency sweep.
module tb_dm_pipelined;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en   [4];
    logic        rd   [4];
    logic        wr   [4];
    logic [13:0] addr [4];
    logic [31:0] din  [4];
    logic [3:0]  be   [4];
    logic [31:0] dout [4];
    logic        rdy  [4];
    logic        err  [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 8;
            dm_pipelined #(
                .DATA_WIDTH (32),
                .ADDR_WIDTH (14),
                .LATENCY    (LAT)
            ) u_dut (
                .clock      (clk),
                .reset      (rst_n),
                .DM_enable  (en[gi]),
                .DM_read    (rd[gi]),
                .DM_write   (wr[gi]),
                .DM_address (addr[gi]),
                .DM_in      (din[gi]),
                .DM_byte_en (be[gi]),
                .DM_out     (dout[gi]),
                .DM_ready   (rdy[gi]),
                .DM_error   (err[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int u);
        case (u)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Presents a request before the next edge and releases it after that edge.
    task automatic issue(input int u, input bit r, input bit w, input logic [13:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        en[u] = 1'b1; rd[u] = r; wr[u] = w; addr[u] = a; din[u] = d; be[u] = b;
        @(posedge clk); #1;
        en[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
        check($sformatf("u%0d accept a=%h", u, a), 32'(rdy[u]), 32'd0);
    endtask

    task automatic wait_done(input int u, output int n);
        n = 0;
        while (!rdy[u] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic access(input int u, input bit r, input bit w, input logic [13:0] a,
                          input logic [31:0] d, input logic [3:0] b, input bit exp_err,
                          input string tag);
        int n;
        issue(u, r, w, a, d, b);
        wait_done(u, n);
        $display("u%0d %s rd=%0b wr=%0b a=%h d=%h be=%h -> lat=%0d out=%h err=%0b",
                 u, tag, r, w, a, d, b, n, dout[u], err[u]);
        check({tag, " lat"}, 32'(n), 32'(lat_of(u)));
        check({tag, " err"}, 32'(err[u]), 32'(exp_err));
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = '0; din[i] = '0; be[i] = '0;
        end
        #2;
        check("reset ready", 32'(rdy[0]), 32'd1);
        check("reset err", 32'(err[0]), 32'd0);
        check("reset out", dout[0], 32'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(1);

        // Write then back-to-back read
        access(0, 0, 1, 14'h10, 32'hDEADBEEF, 4'hF, 0, "wr10");
        access(0, 1, 0, 14'h10, 32'h0, 4'h0, 0, "rd10");
        check("rd10 data", dout[0], 32'hDEADBEEF);

        // Byte strobes
        access(0, 0, 1, 14'h10, 32'h11223344, 4'h5, 0, "wr10 be5");
        access(0, 1, 0, 14'h10, 32'h0, 4'h0, 0, "rd10 be5");
        check("be5 data", dout[0], 32'hDE22BE44);
        access(0, 0, 1, 14'h10, 32'hFFFFFFFF, 4'h0, 0, "wr10 be0");
        access(0, 1, 0, 14'h10, 32'h0, 4'h0, 0, "rd10 be0");
        check("be0 data", dout[0], 32'hDE22BE44);

        // Misaligned accesses
        access(0, 1, 0, 14'h12, 32'h0, 4'h0, 1, "rd12 misaligned");
        check("misaligned out held", dout[0], 32'hDE22BE44);
        idle(1);
        check("err one cycle", 32'(err[0]), 32'd0);
        access(0, 0, 1, 14'h13, 32'h0, 4'hF, 1, "wr13 misaligned");
        access(0, 1, 0, 14'h10, 32'h0, 4'h0, 0, "rd10 after wr13");
        check("wr13 no effect", dout[0], 32'hDE22BE44);

        // Illegal command
        access(0, 1, 1, 14'h10, 32'h0, 4'hF, 1, "rdwr illegal");
        access(0, 1, 0, 14'h10, 32'h0, 4'h0, 0, "rd10 after illegal");
        check("illegal no effect", dout[0], 32'hDE22BE44);

        // Enable while busy is ignored
        access(0, 0, 1, 14'h14, 32'h55AA55AA, 4'hF, 0, "wr14");
        issue(0, 1, 0, 14'h14, 32'h0, 4'h0);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 14'h10; din[0] = 32'h0; be[0] = 4'hF;
        @(posedge clk); #1;
        en[0] = 1'b0; wr[0] = 1'b0;
        check("busy still low", 32'(rdy[0]), 32'd0);
        wait_done(0, n);
        check("busy remaining lat", 32'(n), 32'd1);
        check("busy rd14 data", dout[0], 32'h55AA55AA);
        idle(2);
        check("busy single completion", 32'(rdy[0]), 32'd1);
        access(0, 1, 0, 14'h10, 32'h0, 4'h0, 0, "rd10 after busy");
        check("busy write ignored", dout[0], 32'hDE22BE44);

        // Asynchronous reset drops an in-flight write
        access(0, 0, 1, 14'h20, 32'h0BADC0DE, 4'hF, 0, "wr20 pre");
        issue(0, 0, 1, 14'h20, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #2;
        check("pre-reset busy", 32'(rdy[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async reset ready", 32'(rdy[0]), 32'd1);
        check("async reset out", dout[0], 32'd0);
        check("async reset err", 32'(err[0]), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(1);
        access(0, 1, 0, 14'h20, 32'h0, 4'h0, 0, "rd20 after reset");
        check("reset dropped write", dout[0], 32'h0BADC0DE);

        // Latency sweep with back-to-back reads
        for (int u = 1; u < 4; u++) begin
            access(u, 0, 1, 14'h0, 32'hA000_0000 + 32'(u), 4'hF, 0, $sformatf("L%0d wr0", lat_of(u)));
            access(u, 0, 1, 14'h4, 32'hB000_0000 + 32'(u), 4'hF, 0, $sformatf("L%0d wr4", lat_of(u)));
            access(u, 1, 0, 14'h0, 32'h0, 4'h0, 0, $sformatf("L%0d rd0", lat_of(u)));
            check($sformatf("L%0d rd0 data", lat_of(u)), dout[u], 32'hA000_0000 + 32'(u));
            access(u, 1, 0, 14'h4, 32'h0, 4'h0, 0, $sformatf("L%0d rd4", lat_of(u)));
            check($sformatf("L%0d rd4 data", lat_of(u)), dout[u], 32'hB000_0000 + 32'(u));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
